// File: rtl/lfsr_step_ctrl.sv
// Pacing controller for the 8-bit LFSR display: debounced run/step/speed keys
// drive a RUNNING/PAUSED FSM and a rate-scaled divider that emits a one-cycle tick.
module lfsr_step_ctrl #(
  parameter int DIV_COUNT = 50000000,
  parameter int DEB_COUNT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_run,
  input  logic       key_step,
  input  logic       key_speed,
  output logic       tick,
  output logic       running,
  output logic [1:0] speed,
  output logic [7:0] tick_count
);

  localparam int DIV_W = $clog2(DIV_COUNT);
  localparam int DEB_W = $clog2(DEB_COUNT);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

  localparam int K_RUN   = 0;
  localparam int K_STEP  = 1;
  localparam int K_SPEED = 2;

  typedef enum logic {
    ST_PAUSED  = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  // ---------------- key conditioning ----------------
  logic [2:0]       key_raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       deb_q, deb_d;
  logic [2:0]       press_q, press_d;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];

  assign key_raw = {key_speed, key_step, key_run};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      // NOTE: every output gets a default before any branch, so no path leaves a latch behind.
      deb_d[k]     = deb_q[k];
      deb_cnt_d[k] = '0;
      press_d[k]   = 1'b0;
      if (sync2_q[k] != deb_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          deb_d[k]   = sync2_q[k];
          press_d[k] = ~sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values, as the hardware does.
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      // NOTE: this small counter array is plain flops, so it is reset like any other state.
      for (int k = 0; k < 3; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int k = 0; k < 3; k++) deb_cnt_q[k] <= deb_cnt_d[k];
    end
  end

  // ---------------- FSM, divider, speed ----------------
  logic             run_ev, step_ev, speed_ev;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, last_v;
  logic [1:0]       speed_q, speed_d;
  logic             tick_q, tick_d;
  logic [7:0]       tick_count_q, tick_count_d;

  assign run_ev   = press_q[K_RUN];
  assign step_ev  = press_q[K_STEP];
  assign speed_ev = press_q[K_SPEED];

  always_comb begin
    last_v = DIV_W'(DIV_COUNT - 1);
    case (speed_q)
      2'd1:    last_v = DIV_W'((DIV_COUNT >> 1) - 1);
      2'd2:    last_v = DIV_W'((DIV_COUNT >> 2) - 1);
      2'd3:    last_v = DIV_W'((DIV_COUNT >> 3) - 1);
      default: last_v = DIV_W'(DIV_COUNT - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    speed_d = speed_q;
    tick_d  = 1'b0;

    if (state_q == ST_RUNNING) begin
      if (div_q == last_v) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end else begin
      div_d = '0;
      // A run press in the same cycle takes priority and swallows the step.
      if (step_ev && !run_ev) tick_d = 1'b1;
    end

    if (run_ev) begin
      state_d = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
      div_d   = '0;
    end

    if (speed_ev) begin
      speed_d = speed_q + 2'd1;
      div_d   = '0;
    end

    tick_count_d = tick_count_q + {7'd0, tick_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUNNING;
      div_q        <= '0;
      speed_q      <= '0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      speed_q      <= speed_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
    end
  end

  assign tick       = tick_q;
  assign running    = (state_q == ST_RUNNING);
  assign speed      = speed_q;
  assign tick_count = tick_count_q;

endmodule
